// File: rtl/mem_arb_pkg.sv
// Shared types for the unified RAM port arbiter.
package mem_arb_pkg;
  localparam int LANES = 4;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {SRC_IF, SRC_D} arb_src_t;

  typedef struct packed {
    arb_src_t   src;
    logic       is_byte;
    logic [1:0] lane;
  } rd_tag_t;
endpackage

// File: rtl/byte_lane_steer.sv
// Byte-lane steering: store mask/replication and load lane select with zero-extend.
module byte_lane_steer
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              wr_byte_i,
  input  logic [1:0]        wr_lane_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [LANES-1:0]  wmask_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              rd_byte_i,
  input  logic [1:0]        rd_lane_i,
  input  logic [DATA_W-1:0] rd_raw_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [LANES-1:0][7:0] raw_lanes;

  assign raw_lanes = rd_raw_i;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wmask_o[l]        = wr_byte_i ? (wr_lane_i == 2'(l)) : 1'b1;
    assign wdata_o[8*l +: 8] = wr_byte_i ? wr_data_i[7:0] : wr_data_i[8*l +: 8];
  end

  assign rd_data_o = rd_byte_i ? {{(DATA_W-8){1'b0}}, raw_lanes[rd_lane_i]} : rd_raw_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and D requesters onto one RAM port; data wins unless IF is starved.
// Define ARB_PERF_EN to add grant/conflict performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [15:0]       perf_d_gnt,
  output logic [15:0]       perf_if_gnt,
  output logic [15:0]       perf_conflict
`endif
);
  arb_state_t  state_q, state_d;
  logic [1:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  rd_tag_t     tag_q, tag_d;
  logic        if_rv_q, if_rv_d, d_rv_q, d_rv_d;
  logic        ret, legal, gnt_if, gnt_d, rd_gnt;
  logic [LANES-1:0]  st_wmask;
  logic [DATA_W-1:0] st_wdata, rd_steer;

  // lat_q counts down the cycles left until the outstanding read returns
  assign ret    = (state_q == ARB_BUSY) && (lat_q == 2'd0);
  assign legal  = !rst && ((state_q == ARB_IDLE) || ret);
  assign gnt_d  = legal && d_req && !(if_req && (starve_q == 4'(STARVE_MAX)));
  assign gnt_if = legal && !gnt_d && if_req;
  assign rd_gnt = gnt_if || (gnt_d && !d_we);

  assign if_gnt = gnt_if;
  assign d_gnt  = gnt_d;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    tag_d    = tag_q;
    starve_d = starve_q;
    if (state_q == ARB_BUSY) begin
      if (lat_q != 2'd0) lat_d = lat_q - 2'd1;
      else               state_d = ARB_IDLE;
    end
    if (rd_gnt) begin
      state_d       = ARB_BUSY;
      lat_d         = 2'(MEM_LAT - 1);
      tag_d.src     = gnt_d ? SRC_D : SRC_IF;
      tag_d.is_byte = gnt_d && d_byte;
      tag_d.lane    = gnt_d ? d_addr[1:0] : 2'b00;
    end
    if (!if_req || gnt_if)                           starve_d = 4'd0;
    else if (gnt_d && (starve_q < 4'(STARVE_MAX)))   starve_d = starve_q + 4'd1;
    if_rv_d = (state_d == ARB_BUSY) && (lat_d == 2'd0) && (tag_d.src == SRC_IF);
    d_rv_d  = (state_d == ARB_BUSY) && (lat_d == 2'd0) && (tag_d.src == SRC_D);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      lat_q    <= 2'd0;
      starve_q <= 4'd0;
      tag_q    <= '0;
      if_rv_q  <= 1'b0;
      d_rv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
      if_rv_q  <= if_rv_d;
      d_rv_q   <= d_rv_d;
    end
  end

  byte_lane_steer #(.DATA_W(DATA_W)) u_steer (
    .wr_byte_i (d_byte),
    .wr_lane_i (d_addr[1:0]),
    .wr_data_i (d_wdata),
    .wmask_o   (st_wmask),
    .wdata_o   (st_wdata),
    .rd_byte_i (tag_q.is_byte),
    .rd_lane_i (tag_q.lane),
    .rd_raw_i  (mem_rdata),
    .rd_data_o (rd_steer)
  );

  assign mem_en    = gnt_if || gnt_d;
  assign mem_we    = gnt_d && d_we;
  assign mem_addr  = gnt_d  ? (d_addr  & ~ADDR_W'(3)) :
                     gnt_if ? (if_addr & ~ADDR_W'(3)) : '0;
  assign mem_wmask = mem_we ? st_wmask : 4'h0;
  assign mem_wdata = mem_we ? st_wdata : '0;

  // RAM output is already registered; steering uses the tag before a same-cycle grant replaces it
  assign if_rvalid = if_rv_q;
  assign d_rvalid  = d_rv_q;
  assign if_rdata  = if_rv_q ? mem_rdata : '0;
  assign d_rdata   = d_rv_q  ? rd_steer  : '0;

`ifdef ARB_PERF_EN
  logic [15:0] perf_d_q, perf_if_q, perf_cf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_d_q  <= 16'd0;
      perf_if_q <= 16'd0;
      perf_cf_q <= 16'd0;
    end else begin
      perf_d_q  <= perf_d_q  + 16'(gnt_d);
      perf_if_q <= perf_if_q + 16'(gnt_if);
      perf_cf_q <= perf_cf_q + 16'(if_req && d_req);
    end
  end

  assign perf_d_gnt    = perf_d_q;
  assign perf_if_gnt   = perf_if_q;
  assign perf_conflict = perf_cf_q;
`endif
endmodule
